// File: rtl/dice_if.sv
// Handshake bundle between the dice scheduler and its button, roller and display neighbours.
// The slave side is the scheduler; the master side drives the ticks, requests and roller value.
interface dice_if;
  logic       tick;
  logic       req1;
  logic       req2;
  logic [3:0] dice_val;
  logic       roll_en;
  logic       roll_sel;
  logic [3:0] dice1;
  logic [3:0] dice2;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [3:0] round;
  logic       busy;
  logic       finish;
  logic [1:0] winner;

  modport master (
    output tick, req1, req2, dice_val,
    input  roll_en, roll_sel, dice1, dice2, score1, score2, round, busy, finish, winner
  );

  modport slave (
    input  tick, req1, req2, dice_val,
    output roll_en, roll_sel, dice1, dice2, score1, score2, round, busy, finish, winner
  );
endinterface

// File: rtl/dice_turn_scheduler.sv
// Two-player dice game sequencer: alternates roller ownership, times rolls and result display
// from the prescaled tick, judges rounds, keeps saturating scores and declares the winner.
module dice_turn_scheduler #(
  parameter int ROLL_TICKS = 50,
  parameter int SHOW_TICKS = 100,
  parameter int ROUNDS     = 5
) (
  input  logic   clk,
  input  logic   rst,
  dice_if.slave  bus
);

  localparam logic [2:0] S_WAIT1 = 3'd0;
  localparam logic [2:0] S_ROLL1 = 3'd1;
  localparam logic [2:0] S_WAIT2 = 3'd2;
  localparam logic [2:0] S_ROLL2 = 3'd3;
  localparam logic [2:0] S_JUDGE = 3'd4;
  localparam logic [2:0] S_SHOW  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam int MAXT = (ROLL_TICKS > SHOW_TICKS) ? ROLL_TICKS : SHOW_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] ROLL_LAST = CW'(ROLL_TICKS - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_TICKS - 1);
  localparam logic [3:0]    LAST_RND  = 4'(ROUNDS);

  logic [2:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [3:0]    dice1_q,  dice1_d;
  logic [3:0]    dice2_q,  dice2_d;
  logic [3:0]    score1_q, score1_d;
  logic [3:0]    score2_q, score2_d;
  logic [3:0]    round_q,  round_d;
  logic [1:0]    winner_q, winner_d;
  logic          roll_en_q, roll_en_d;
  logic          roll_sel_q, roll_sel_d;
  logic          busy_q,   busy_d;
  logic          finish_q, finish_d;

  function automatic logic [3:0] clamp(input logic [3:0] v);
    if (v == 4'd0)     return 4'd1;
    else if (v > 4'd6) return 4'd6;
    else               return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dice1_d  = dice1_q;
    dice2_d  = dice2_q;
    score1_d = score1_q;
    score2_d = score2_q;
    round_d  = round_q;
    winner_d = winner_q;
    case (state_q)
      S_WAIT1: if (bus.req1) state_d = S_ROLL1;
      S_ROLL1: if (bus.tick) begin
        if (cnt_q == ROLL_LAST) begin
          cnt_d   = '0;
          dice1_d = clamp(bus.dice_val);
          state_d = S_WAIT2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT2: if (bus.req2) state_d = S_ROLL2;
      S_ROLL2: if (bus.tick) begin
        if (cnt_q == ROLL_LAST) begin
          cnt_d   = '0;
          dice2_d = clamp(bus.dice_val);
          state_d = S_JUDGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_JUDGE: begin
        if (dice1_q > dice2_q && score1_q < 4'd9) score1_d = score1_q + 4'd1;
        if (dice2_q > dice1_q && score2_q < 4'd9) score2_d = score2_q + 4'd1;
        state_d = S_SHOW;
      end
      S_SHOW: if (bus.tick) begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (round_q == LAST_RND) begin
            // Scores are final here, so the verdict lands on the same edge as DONE.
            if (score1_q > score2_q)      winner_d = 2'b01;
            else if (score2_q > score1_q) winner_d = 2'b10;
            else                          winner_d = 2'b11;
            state_d = S_DONE;
          end else begin
            round_d = round_q + 4'd1;
            dice1_d = '0;
            dice2_d = '0;
            state_d = S_WAIT1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: if (bus.req1) begin
        score1_d = '0;
        score2_d = '0;
        dice1_d  = '0;
        dice2_d  = '0;
        winner_d = '0;
        round_d  = 4'd1;
        state_d  = S_WAIT1;
      end
      default: state_d = S_WAIT1;
    endcase
    // Flag outputs are registered copies of the next state's decode.
    roll_en_d  = (state_d == S_ROLL1) || (state_d == S_ROLL2);
    roll_sel_d = (state_d == S_WAIT2) || (state_d == S_ROLL2);
    busy_d     = (state_d == S_ROLL1) || (state_d == S_ROLL2) ||
                 (state_d == S_JUDGE) || (state_d == S_SHOW);
    finish_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_WAIT1;
      cnt_q      <= '0;
      dice1_q    <= '0;
      dice2_q    <= '0;
      score1_q   <= '0;
      score2_q   <= '0;
      round_q    <= 4'd1;
      winner_q   <= '0;
      roll_en_q  <= 1'b0;
      roll_sel_q <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dice1_q    <= dice1_d;
      dice2_q    <= dice2_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      round_q    <= round_d;
      winner_q   <= winner_d;
      roll_en_q  <= roll_en_d;
      roll_sel_q <= roll_sel_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
    end
  end

  assign bus.roll_en  = roll_en_q;
  assign bus.roll_sel = roll_sel_q;
  assign bus.dice1    = dice1_q;
  assign bus.dice2    = dice2_q;
  assign bus.score1   = score1_q;
  assign bus.score2   = score2_q;
  assign bus.round    = round_q;
  assign bus.busy     = busy_q;
  assign bus.finish   = finish_q;
  assign bus.winner   = winner_q;

endmodule

// File: tb/tb_dice_turn_scheduler.sv
// Directed bench for dice_turn_scheduler: per-cycle vector table plus a gated-tick roll sequence.
module tb_dice_turn_scheduler;
  logic clk = 1'b0;
  logic rst;
  dice_if u_if ();

  dice_turn_scheduler #(.ROLL_TICKS(3), .SHOW_TICKS(2), .ROUNDS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, tick, req1, req2;
    logic [3:0]  dv;
    logic [29:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Expected output vector order: en sel d1 d2 s1 s2 round busy finish winner.
  task automatic add(input int r, t, a, b, dv, en, sel, d1, d2, s1, s2, rn, bz, fn, w);
    vec_t v;
    v.rst  = 1'(r);
    v.tick = 1'(t);
    v.req1 = 1'(a);
    v.req2 = 1'(b);
    v.dv   = 4'(dv);
    v.exp  = {1'(en), 1'(sel), 4'(d1), 4'(d2), 4'(s1), 4'(s2), 4'(rn), 1'(bz), 1'(fn), 2'(w)};
    vecs.push_back(v);
  endtask

  function automatic logic [29:0] outs();
    return {u_if.roll_en, u_if.roll_sel, u_if.dice1, u_if.dice2, u_if.score1, u_if.score2,
            u_if.round, u_if.busy, u_if.finish, u_if.winner};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int hi;
    int done;
    rst = 1'b1;
    u_if.tick = 1'b0;
    u_if.req1 = 1'b0;
    u_if.req2 = 1'b0;
    u_if.dice_val = 4'd0;

    // Full game: 5 vs 2 then 3 vs 4, ending in a draw.
    add(1,1,0,0,0,  0,0,0,0,0,0,1,0,0,0);
    add(0,1,1,0,5,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,0,5,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,0,5,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,0,5,  0,1,5,0,0,0,1,0,0,0);
    add(0,1,0,1,2,  1,1,5,0,0,0,1,1,0,0);
    add(0,1,0,0,2,  1,1,5,0,0,0,1,1,0,0);
    add(0,1,0,0,2,  1,1,5,0,0,0,1,1,0,0);
    add(0,1,0,0,2,  0,0,5,2,0,0,1,1,0,0);
    add(0,1,0,0,0,  0,0,5,2,1,0,1,1,0,0);
    add(0,1,0,0,0,  0,0,5,2,1,0,1,1,0,0);
    add(0,1,0,0,0,  0,0,0,0,1,0,2,0,0,0);
    add(0,1,1,0,3,  1,0,0,0,1,0,2,1,0,0);
    add(0,1,0,0,3,  1,0,0,0,1,0,2,1,0,0);
    add(0,1,0,0,3,  1,0,0,0,1,0,2,1,0,0);
    add(0,1,0,0,3,  0,1,3,0,1,0,2,0,0,0);
    add(0,1,0,1,4,  1,1,3,0,1,0,2,1,0,0);
    add(0,1,0,0,4,  1,1,3,0,1,0,2,1,0,0);
    add(0,1,0,0,4,  1,1,3,0,1,0,2,1,0,0);
    add(0,1,0,0,4,  0,0,3,4,1,0,2,1,0,0);
    add(0,1,0,0,0,  0,0,3,4,1,1,2,1,0,0);
    add(0,1,0,0,0,  0,0,3,4,1,1,2,1,0,0);
    add(0,1,0,0,0,  0,0,3,4,1,1,2,0,1,3);
    add(0,1,0,1,0,  0,0,3,4,1,1,2,0,1,3);
    add(0,1,1,0,0,  0,0,0,0,0,0,1,0,0,0);
    // Out-of-order requests, clamping, tie round, player 2 wins.
    add(0,1,0,1,0,  0,0,0,0,0,0,1,0,0,0);
    add(0,1,1,1,0,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,1,0,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,1,0,0,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,0,0,  0,1,1,0,0,0,1,0,0,0);
    add(0,1,1,0,9,  0,1,1,0,0,0,1,0,0,0);
    add(0,1,0,1,9,  1,1,1,0,0,0,1,1,0,0);
    add(0,1,0,0,9,  1,1,1,0,0,0,1,1,0,0);
    add(0,1,0,0,9,  1,1,1,0,0,0,1,1,0,0);
    add(0,1,0,0,9,  0,0,1,6,0,0,1,1,0,0);
    add(0,1,0,0,0,  0,0,1,6,0,1,1,1,0,0);
    add(0,1,0,0,0,  0,0,1,6,0,1,1,1,0,0);
    add(0,1,0,0,0,  0,0,0,0,0,1,2,0,0,0);
    add(0,1,1,0,6,  1,0,0,0,0,1,2,1,0,0);
    add(0,1,0,0,6,  1,0,0,0,0,1,2,1,0,0);
    add(0,1,0,0,6,  1,0,0,0,0,1,2,1,0,0);
    add(0,1,0,0,6,  0,1,6,0,0,1,2,0,0,0);
    add(0,1,0,1,8,  1,1,6,0,0,1,2,1,0,0);
    add(0,1,0,0,8,  1,1,6,0,0,1,2,1,0,0);
    add(0,1,0,0,8,  1,1,6,0,0,1,2,1,0,0);
    add(0,1,0,0,8,  0,0,6,6,0,1,2,1,0,0);
    add(0,1,0,0,0,  0,0,6,6,0,1,2,1,0,0);
    add(0,1,0,0,0,  0,0,6,6,0,1,2,1,0,0);
    add(0,1,0,0,0,  0,0,6,6,0,1,2,0,1,2);
    add(0,1,1,0,0,  0,0,0,0,0,0,1,0,0,0);
    // Reset in the middle of ROLL2 with score1=1, then a clean roll afterwards.
    add(0,1,1,0,5,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,0,5,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,0,5,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,0,5,  0,1,5,0,0,0,1,0,0,0);
    add(0,1,0,1,2,  1,1,5,0,0,0,1,1,0,0);
    add(0,1,0,0,2,  1,1,5,0,0,0,1,1,0,0);
    add(0,1,0,0,2,  1,1,5,0,0,0,1,1,0,0);
    add(0,1,0,0,2,  0,0,5,2,0,0,1,1,0,0);
    add(0,1,0,0,0,  0,0,5,2,1,0,1,1,0,0);
    add(0,1,0,0,0,  0,0,5,2,1,0,1,1,0,0);
    add(0,1,0,0,0,  0,0,0,0,1,0,2,0,0,0);
    add(0,1,1,0,3,  1,0,0,0,1,0,2,1,0,0);
    add(0,1,0,0,3,  1,0,0,0,1,0,2,1,0,0);
    add(0,1,0,0,3,  1,0,0,0,1,0,2,1,0,0);
    add(0,1,0,0,3,  0,1,3,0,1,0,2,0,0,0);
    add(0,1,0,1,3,  1,1,3,0,1,0,2,1,0,0);
    add(0,1,0,0,3,  1,1,3,0,1,0,2,1,0,0);
    add(1,1,0,0,3,  0,0,0,0,0,0,1,0,0,0);
    add(0,1,0,0,3,  0,0,0,0,0,0,1,0,0,0);
    add(0,1,1,0,4,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,0,4,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,0,4,  1,0,0,0,0,0,1,1,0,0);
    add(0,1,0,0,4,  0,1,4,0,0,0,1,0,0,0);

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      u_if.tick     = vecs[i].tick;
      u_if.req1     = vecs[i].req1;
      u_if.req2     = vecs[i].req2;
      u_if.dice_val = vecs[i].dv;
      step();
      n_vec++;
      if (outs() !== vecs[i].exp) begin
        n_err++;
        $display("FAIL vec%0d: got %h expected %h", i, outs(), vecs[i].exp);
      end
    end

    // Gated ticks (every 4th cycle): roll spans 3 tick pulses, stray requests dropped.
    rst = 1'b1; u_if.req1 = 1'b0; u_if.req2 = 1'b0; u_if.tick = 1'b0;
    step();
    rst = 1'b0; u_if.req1 = 1'b1; u_if.dice_val = 4'd7;
    step();
    check("gated_start", int'(u_if.roll_en), 1);
    u_if.req1 = 1'b0;
    hi = 1;
    done = 0;
    for (int i = 0; i < 50 && done == 0; i++) begin
      u_if.tick = (i % 4 == 3);
      u_if.req2 = (i == 5);
      u_if.req1 = (i == 6);
      step();
      if (u_if.roll_en) hi++;
      else done = 1;
    end
    u_if.tick = 1'b0; u_if.req1 = 1'b0; u_if.req2 = 1'b0;
    check("gated_timeout", done, 1);
    check("gated_roll_len", hi, 12);
    check("gated_dice1", int'(u_if.dice1), 6);
    check("gated_sel", int'(u_if.roll_sel), 1);
    check("gated_busy", int'(u_if.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dice_turn_scheduler.md
# dice_turn_scheduler

Sequences the two-player dice game. It arbitrates the single shared dice roller between player 1 and player 2, enforcing strict alternation. It times each roll and display phase from a prescaled tick, latches both dice, judges each round, keeps scores, and ends the game after a fixed number of rounds. It sits between the debounced start buttons and the roller / score / display blocks.

## Interface
Parameters:
- ROLL_TICKS, 50, ticks the roller stays enabled per roll (≥1)
- SHOW_TICKS, 100, ticks the round result is held before the next round (≥1)
- ROUNDS, 5, rounds per game (1..9)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- tick  in  1  one-cycle enable strobe from the prescaler, synchronous to clk
- req1  in  1  player 1 debounced press, one-cycle pulse
- req2  in  1  player 2 debounced press, one-cycle pulse
- dice_val  in  4  live roller value, nominally 1..6
- roll_en  out  1  enables the roller
- roll_sel  out  1  roller owner: 0 = player 1, 1 = player 2
- dice1  out  4  latched player 1 result
- dice2  out  4  latched player 2 result
- score1  out  4  player 1 rounds won
- score2  out  4  player 2 rounds won
- round  out  4  current round number, 1..ROUNDS
- busy  out  1  high in ROLL1, ROLL2, JUDGE and SHOW
- finish  out  1  high in DONE
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw

## Operation
- All outputs are registered.
- Reset values: state WAIT1, round=1, all other outputs 0, tick counter 0.
- States and transitions:
  - WAIT1: on req1 → ROLL1. req2 is ignored.
  - ROLL1: roll_en=1, roll_sel=0. Counts ticks. On the tick with count==ROLL_TICKS-1: latch dice1 from clamped dice_val, clear the counter, → WAIT2.
  - WAIT2: roll_sel=1. On req2 → ROLL2. req1 is ignored.
  - ROLL2: roll_en=1, roll_sel=1. Same counting rule. On the final tick: latch dice2, → JUDGE.
  - JUDGE: lasts exactly 1 cycle. If dice1>dice2, score1+1. If dice2>dice1, score2+1. On equality, neither score changes. → SHOW.
  - SHOW: holds dice1, dice2 and the scores for SHOW_TICKS ticks. Then:
    - if round==ROUNDS → DONE;
    - otherwise round+1, dice1=dice2=0, → WAIT1.
  - DONE: finish=1. winner is set on entry: 01 if score1>score2, 10 if score2>score1, 11 if equal. On req1: score1, score2, dice1, dice2 and winner are cleared, finish=0, round=1, → WAIT1.
- Clamping of dice_val: 0 latches as 1; values >6 latch as 6.
- Scores saturate at 9.
- Requests are not queued.
  - A request arriving in any state other than the one that accepts it is dropped.
  - Simultaneous req1 and req2 in WAIT1: req1 is accepted, req2 is dropped.
- roll_sel is 0 in WAIT1, JUDGE, SHOW and DONE.
- Reset mid-operation: any state returns to the full reset values on the next edge. Partial results are discarded.

## Timing
- Request to roll: req1 high at edge n → roll_en=1 from after edge n.
- A roll lasts exactly ROLL_TICKS tick pulses. The counter advances only on cycles with tick=1.
- roll_en falls after the edge that samples the final tick. The dice register updates on that same edge.
- JUDGE lasts 1 clk. The score update is visible one cycle after dice2 latches.
- SHOW starts counting from the first tick after entry. A tick coincident with the JUDGE→SHOW edge is not counted.
- winner and finish become valid on the same edge as entry to DONE.
- tick pulses in WAIT1, WAIT2 and DONE are ignored. The counter stays 0 there.

## Test plan
- Full game. Parameters: ROUNDS=2, ROLL_TICKS=3, SHOW_TICKS=2, tick every cycle. Player dice values 5,2 then 3,4.
  - Required: score1=1, score2=1, winner=11, finish=1.
  - Required: roll_en high exactly 3 cycles per roll.
- Out-of-order requests.
  - req2 in WAIT1 → no state change.
  - req1 in WAIT2 → no state change.
  - req1 and req2 together in WAIT1 → only ROLL1 entered, roll_sel=0.
- Clamping.
  - dice_val=0 at the final tick → dice1=1.
  - dice_val=9 → dice2=6.
- Reset mid-ROLL2 with score1=1.
  - rst one cycle → next cycle state WAIT1, round=1, score1=0, roll_en=0, dice1=0.
- Tick gating.
  - tick every 4th cycle with ROLL_TICKS=3 → roll_en high for the span of 3 tick pulses. Requests during ROLL1 are dropped.
- Restart after DONE: req1 in DONE → finish=0, winner=00, round=1, scores 0, state WAIT1.
